tensor3d_writer: RTL and testbench

//   Write-side companion to the 3D tensor lookup blocks: fills an internal DZ x DY x DX cube

---
 rtl/tensor3d_pkg.sv | 26 ++
 rtl/tensor3d_cursor.sv | 54 +++++
 rtl/tensor3d_writer.sv | 120 ++++++++++++
 tb/tb_tensor3d_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor3d_pkg.sv
// Shared definitions for the 3D tensor blocks: fill-FSM state encoding,
// coordinate-width helper and the on-chip pattern value.
package tensor3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Width of a coordinate able to address n positions (at least one bit).
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Linear raster index of (z,y,x); callers truncate to the element width.
  function automatic int unsigned pattern_value(input int unsigned z,
                                                input int unsigned y,
                                                input int unsigned x,
                                                input int unsigned dy,
                                                input int unsigned dx);
    return z * dy * dx + y * dx + x;
  endfunction

endpackage

// File: rtl/tensor3d_cursor.sv
// Nested z/y/x wrap counter: x fastest, wraps to origin after the last element.
module tensor3d_cursor
  import tensor3d_pkg::*;
#(
  parameter int unsigned DZ = 4,
  parameter int unsigned DY = 4,
  parameter int unsigned DX = 4,
  localparam int unsigned ZW = coord_w(DZ),
  localparam int unsigned YW = coord_w(DY),
  localparam int unsigned XW = coord_w(DX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [ZW-1:0] z,
  output logic [YW-1:0] y,
  output logic [XW-1:0] x,
  output logic          last
);

  logic x_end, y_end, z_end;

  assign x_end = (x == XW'(DX - 1));
  assign y_end = (y == YW'(DY - 1));
  assign z_end = (z == ZW'(DZ - 1));
  assign last  = x_end && y_end && z_end;

  // Advance the cursor; clear or a step past the final element returns to origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
      y <= '0;
      x <= '0;
    end else if (clr || (inc && last)) begin
      z <= '0;
      y <= '0;
      x <= '0;
    end else if (inc) begin
      if (x_end) begin
        x <= '0;
        if (y_end) begin
          y <= '0;
          z <= z + ZW'(1);
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/tensor3d_writer.sv
// Fills a DZ x DY x DX cube from a valid/ready byte stream or with an on-chip
// coordinate pattern; exposes a combinational random-access read port.
module tensor3d_writer
  import tensor3d_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned DZ = 4,
  parameter int unsigned DY = 4,
  parameter int unsigned DX = 4,
  localparam int unsigned ZW = coord_w(DZ),
  localparam int unsigned YW = coord_w(DY),
  localparam int unsigned XW = coord_w(DX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_stream,
  input  logic          start_pattern,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [ZW-1:0] cur_z,
  output logic [YW-1:0] cur_y,
  output logic [XW-1:0] cur_x,
  input  logic [ZW-1:0] rd_z,
  input  logic [YW-1:0] rd_y,
  input  logic [XW-1:0] rd_x,
  output logic [DW-1:0] rd_data
);

  state_t          state, state_nx;
  logic            clr, inc, we, last;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   cube [DZ][DY][DX];

  tensor3d_cursor #(
    .DZ (DZ),
    .DY (DY),
    .DX (DX)
  ) u_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .z     (cur_z),
    .y     (cur_y),
    .x     (cur_x),
    .last  (last)
  );

  assign in_ready = (state == ST_STREAM);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // Next-state, write strobe and cursor control; abort takes priority over any write.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    inc      = 1'b0;
    we       = 1'b0;
    wdata    = in_data;
    case (state)
      ST_IDLE: begin
        if (start_pattern) begin
          state_nx = ST_PATTERN;
          clr      = 1'b1;
        end else if (start_stream) begin
          state_nx = ST_STREAM;
          clr      = 1'b1;
        end
      end
      ST_PATTERN: begin
        if (abort) begin
          state_nx = ST_IDLE;
          clr      = 1'b1;
        end else begin
          we    = 1'b1;
          inc   = 1'b1;
          wdata = DW'(pattern_value(32'(cur_z), 32'(cur_y), 32'(cur_x), DY, DX));
          if (last) state_nx = ST_DONE;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          state_nx = ST_IDLE;
          clr      = 1'b1;
        end else if (in_valid) begin
          we  = 1'b1;
          inc = 1'b1;
          if (last) state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Fill-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Single write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) cube[cur_z][cur_y][cur_x] <= wdata;
  end

  // Combinational read; coordinates beyond the extent return zero.
  always_comb begin
    rd_data = '0;
    if (({1'b0, rd_z} < (ZW + 1)'(DZ)) &&
        ({1'b0, rd_y} < (YW + 1)'(DY)) &&
        ({1'b0, rd_x} < (XW + 1)'(DX)))
      rd_data = cube[rd_z][rd_y][rd_x];
  end

endmodule

// File: tb/tb_tensor3d_writer.sv
// Scoreboard bench for tensor3d_writer: stimulus keeps a flat reference image
// of the cube and queues expected done cycles; a monitor checks every done pulse.
module tb_tensor3d_writer;

  localparam int DW = 8;
  localparam int DZ = 4;
  localparam int DY = 4;
  localparam int DX = 4;
  localparam int N  = DZ * DY * DX;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_stream, start_pattern, abort, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, busy, done;
  logic [1:0]    cur_z, cur_y, cur_x;
  logic [1:0]    rd_z, rd_y, rd_x;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_q [$];

  logic [7:0] model [N];
  bit         known [N];

  tensor3d_writer #(
    .DW (DW),
    .DZ (DZ),
    .DY (DY),
    .DX (DX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_stream  (start_stream),
    .start_pattern (start_pattern),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .cur_z         (cur_z),
    .cur_y         (cur_y),
    .cur_x         (cur_x),
    .rd_z          (rd_z),
    .rd_y          (rd_y),
    .rd_x          (rd_x),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Packed {z,y,x} of raster index i.
  function automatic logic [5:0] coords(int i);
    return {2'(i / (DY * DX)), 2'((i / DX) % DY), 2'(i % DX)};
  endfunction

  // Monitor: every done pulse must match the next expected cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic rd_check(string nm, int i, logic [7:0] exp);
    {rd_z, rd_y, rd_x} = coords(i);
    #1;
    chk(nm, {24'b0, rd_data}, {24'b0, exp});
  endtask

  task automatic cmp_all();
    for (int i = 0; i < N; i++)
      if (known[i]) rd_check("rd_sweep", i, model[i]);
  endtask

  task automatic chk_idle();
    chk("busy_idle", busy, 0);
    chk("ready_idle", in_ready, 0);
    chk("cur_idle", coords(0), {cur_z, cur_y, cur_x});
  endtask

  // Pattern fill; abort_after >= 0 aborts in place of that element's write.
  task automatic pattern_fill(bit both, bit poke, int abort_after);
    int n;
    @(negedge clk);
    start_pattern = 1'b1;
    start_stream  = both;
    n = cyc + 1;
    if (abort_after < 0) done_q.push_back(n + N);
    @(negedge clk);
    start_pattern = 1'b0;
    start_stream  = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("pat_cursor", {cur_z, cur_y, cur_x}, coords(k));
      chk("pat_ready", in_ready, 0);
      chk("pat_busy", busy, 1);
      if (k == abort_after) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle();
        return;
      end
      start_stream = poke ? 1'($urandom % 2) : 1'b0;
      @(negedge clk);
      model[k] = 8'(k);
      known[k] = 1'b1;
    end
    start_stream = 1'b0;
    chk("pat_done_ready", in_ready, 0);
    @(negedge clk);
    chk_idle();
  endtask

  // Stream fill; mode 0: data FF-i with every third cycle idle, 1: random, 2: constant 55.
  task automatic stream_fill(int nbeats, int mode);
    int beat = 0;
    int t = 0;
    bit v;
    logic [7:0] d;
    @(negedge clk) start_stream = 1'b1;
    @(negedge clk) start_stream = 1'b0;
    while (beat < nbeats && t < 4 * nbeats + 8) begin
      chk("str_ready", in_ready, 1);
      chk("str_cursor", {cur_z, cur_y, cur_x}, coords(beat));
      case (mode)
        0:       begin v = (t % 3 != 2);        d = 8'(255 - beat); end
        1:       begin v = ($urandom % 4 != 0); d = 8'($urandom);   end
        default: begin v = 1'b1;                d = 8'h55;          end
      endcase
      in_valid = v;
      in_data  = d;
      if (known[beat]) rd_check("rd_before_write", beat, model[beat]);
      if (v && beat == N - 1) done_q.push_back(cyc + 1);
      @(negedge clk);
      if (v) begin
        model[beat] = d;
        known[beat] = 1'b1;
        beat++;
      end
      t++;
    end
    in_valid = 1'b0;
    if (beat != nbeats) chk("str_budget", beat, nbeats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_stream = 1'b0; start_pattern = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    rd_z = '0; rd_y = '0; rd_x = '0;
    for (int i = 0; i < N; i++) known[i] = 1'b0;

    // Reset state, held and after release.
    repeat (3) @(negedge clk);
    chk_idle();
    chk("done_reset", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle();
    abort = 1'b1;                       // abort in IDLE must do nothing
    @(negedge clk);
    abort = 1'b0;
    chk_idle();

    // Full pattern fill.
    pattern_fill(1'b0, 1'b0, -1);
    rd_check("pat_321", 3 * 16 + 2 * 4 + 1, 8'h39);
    rd_check("pat_000", 0, 8'h00);
    rd_check("pat_333", N - 1, 8'h3F);
    cmp_all();

    // Stream FF-i with gaps.
    stream_fill(N, 0);
    chk("str_end_ready", in_ready, 0);
    @(negedge clk);
    chk_idle();
    rd_check("str_000", 0, 8'hFF);
    rd_check("str_333", N - 1, 8'hC0);

    // Pattern aborted after five writes; element 5 keeps its stream value.
    pattern_fill(1'b0, 1'b0, 5);
    cmp_all();

    // Both starts together with start_stream pokes during fill, then partial stream + abort.
    pattern_fill(1'b1, 1'b1, -1);
    stream_fill(10, 2);
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;                   // coincides with abort: must not land
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_idle();
    rd_check("abort_021", 2 * 4 + 1, 8'h55);
    rd_check("abort_022", 2 * 4 + 2, 8'h0A);
    cmp_all();

    // Asynchronous reset mid-stream, then a clean random stream.
    stream_fill(20, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stream_fill(N, 1);
    chk("rand_end_ready", in_ready, 0);
    @(negedge clk);
    chk_idle();
    cmp_all();

    repeat (3) @(negedge clk);
    chk("done_queue_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
